fadc_frame_align: RTL and testbench

Per-ADC frame alignment controller. It sits directly downstream of the fast ADC DDR deserializer, which exposes the 8-bit deserialized FRAME (nominally 8'b11110000), and feeds back to that deserializer's bit-slip and IDELAY tap controls. It searches bit-slip positions, then IDELAY taps, until the frame matches the pattern stably. It reports lock, and re-acquires automatically if lock is lost. One instance is used per fast ADC (five total).

---
 rtl/fadc_frame_align_if.sv | 23 ++
 rtl/fadc_frame_align.sv | 176 +++++++++++++++++
 tb/tb_fadc_frame_align.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadc_frame_align_if.sv
// Frame-alignment bus between the fast ADC deserializer side and the alignment controller.
// The controller takes the slave view; whatever feeds fr_in and consumes the tap/slip controls takes the master view.
interface fadc_frame_align_if;
  logic       start;
  logic [7:0] fr_in;
  logic       bitslip;
  logic       dly_ld;
  logic [4:0] dly_tap;
  logic [2:0] slip_cnt;
  logic       locked;
  logic       fail;
  logic       busy;

  modport master (
    output start, fr_in,
    input  bitslip, dly_ld, dly_tap, slip_cnt, locked, fail, busy
  );

  modport slave (
    input  start, fr_in,
    output bitslip, dly_ld, dly_tap, slip_cnt, locked, fail, busy
  );
endinterface

// File: rtl/fadc_frame_align.sv
// Per-ADC frame alignment controller: walks bit-slip positions, then IDELAY taps,
// until the deserialized frame word matches FRAME_PATTERN stably; reacquires on loss of lock.
module fadc_frame_align #(
  parameter int         NUM_BITS      = 8,
  parameter logic [7:0] FRAME_PATTERN = 8'b11110000,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         VERIFY_COUNT  = 64,
  parameter int         MAX_TAPS      = 32,
  parameter int         LOSS_COUNT    = 4
) (
  input logic clk100,
  input logic rst,
  fadc_frame_align_if.slave bus
);

  localparam int TAP_W    = 5;
  localparam int SLIP_W   = 3;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int MATCH_W  = $clog2(VERIFY_COUNT + 1);
  localparam int LOSS_W   = $clog2(LOSS_COUNT + 1);

  localparam logic [TAP_W-1:0]    LAST_TAP    = TAP_W'(MAX_TAPS - 1);
  localparam logic [SLIP_W-1:0]   LAST_SLIP   = SLIP_W'(NUM_BITS - 1);
  localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  VERIFY_DONE = MATCH_W'(VERIFY_COUNT);
  localparam logic [LOSS_W-1:0]   LAST_LOSS   = LOSS_W'(LOSS_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    DELAY,
    LOCKED,
    FAIL
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [TAP_W-1:0]    tap_q;
  logic [TAP_W-1:0]    tap_nx;
  logic [SLIP_W-1:0]   slip_q;
  logic [SLIP_W-1:0]   slip_nx;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_nx;
  logic [MATCH_W-1:0]  match_q;
  logic [MATCH_W-1:0]  match_nx;
  logic [LOSS_W-1:0]   loss_q;
  logic [LOSS_W-1:0]   loss_nx;
  logic                dly_ld_q;
  logic                dly_ld_nx;
  logic                restart;
  logic                frame_ok;

  assign frame_ok = (bus.fr_in == FRAME_PATTERN);

  always_ff @(posedge clk100) begin
    if (rst) begin
      state    <= IDLE;
      tap_q    <= '0;
      slip_q   <= '0;
      settle_q <= '0;
      match_q  <= '0;
      loss_q   <= '0;
      dly_ld_q <= 1'b0;
    end else begin
      state    <= state_nx;
      tap_q    <= tap_nx;
      slip_q   <= slip_nx;
      settle_q <= settle_nx;
      match_q  <= match_nx;
      loss_q   <= loss_nx;
      dly_ld_q <= dly_ld_nx;
    end
  end

  // A restart (start, or lock lost) always reloads tap 0 / slip 0 and settles again.
  always_comb begin
    state_nx  = state;
    tap_nx    = tap_q;
    slip_nx   = slip_q;
    settle_nx = settle_q;
    match_nx  = match_q;
    loss_nx   = loss_q;
    dly_ld_nx = 1'b0;
    restart   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          restart = 1'b1;
        end
      end

      SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          state_nx = CHECK;
          match_nx = '0;
        end else begin
          settle_nx = settle_q + 1'b1;
        end
      end

      // The verify count is registered, so LOCKED follows one cycle after the last match.
      CHECK: begin
        if (match_q == VERIFY_DONE) begin
          state_nx = LOCKED;
          loss_nx  = '0;
        end else if (frame_ok) begin
          match_nx = match_q + 1'b1;
        end else if (slip_q < LAST_SLIP) begin
          state_nx = SLIP;
        end else begin
          state_nx = DELAY;
        end
      end

      SLIP: begin
        slip_nx   = slip_q + 1'b1;
        settle_nx = '0;
        state_nx  = SETTLE;
      end

      DELAY: begin
        if (tap_q == LAST_TAP) begin
          state_nx = FAIL;
        end else begin
          tap_nx    = tap_q + 1'b1;
          slip_nx   = '0;
          settle_nx = '0;
          dly_ld_nx = 1'b1;
          state_nx  = SETTLE;
        end
      end

      LOCKED: begin
        if (bus.start) begin
          restart = 1'b1;
        end else if (frame_ok) begin
          loss_nx = '0;
        end else if (loss_q == LAST_LOSS) begin
          restart = 1'b1;
        end else begin
          loss_nx = loss_q + 1'b1;
        end
      end

      FAIL: begin
        if (bus.start) begin
          restart = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    if (restart) begin
      state_nx  = SETTLE;
      tap_nx    = '0;
      slip_nx   = '0;
      settle_nx = '0;
      dly_ld_nx = 1'b1;
    end
  end

  assign bus.bitslip  = (state == SLIP);
  assign bus.dly_ld   = dly_ld_q;
  assign bus.dly_tap  = tap_q;
  assign bus.slip_cnt = slip_q;
  assign bus.locked   = (state == LOCKED);
  assign bus.fail     = (state == FAIL);
  assign bus.busy     = !((state == IDLE) || (state == LOCKED) || (state == FAIL));

endmodule

// File: tb/tb_fadc_frame_align.sv
// Self-checking bench for fadc_frame_align: a deserializer model rotates the frame on each
// bit-slip and can gate the good frame on the IDELAY tap; expected timing comes from attempt counts.
module tb_fadc_frame_align;

  localparam logic [7:0] PAT = 8'hF0;

  logic clk100 = 1'b0;
  logic rst;

  fadc_frame_align_if bus ();

  fadc_frame_align dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk100 = ~clk100;

  typedef enum {M_CONST, M_ROT, M_TAP} mode_t;

  int         vectors     = 0;
  int         miscompares = 0;
  mode_t      mode        = M_CONST;
  logic [7:0] const_val   = 8'h00;
  logic [7:0] rot_base    = 8'h00;
  int         rot         = 0;
  int         good_tap    = 0;
  int         cyc         = 0;
  int         slips_seen  = 0;
  int         overlap_seen = 0;
  int         min_gap     = 1000000;
  int         last_slip_cyc = -1;
  int         ld_taps[$];

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] garbage();
    logic [7:0] v;
    do v = 8'($urandom); while (v == PAT);
    return v;
  endfunction

  // Deserializer model: output word as a function of slips seen and the loaded tap.
  function automatic logic [7:0] frame_model();
    case (mode)
      M_ROT:   return rotl(rot_base, rot);
      M_TAP:   return (int'(bus.dly_tap) >= good_tap) ? PAT : garbage();
      default: return const_val;
    endcase
  endfunction

  task automatic refresh();
    bus.fr_in = frame_model();
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
    cyc++;
    if (bus.bitslip === 1'b1) begin
      rot++;
      slips_seen++;
      if (last_slip_cyc >= 0 && (cyc - last_slip_cyc) < min_gap) min_gap = cyc - last_slip_cyc;
      last_slip_cyc = cyc;
    end
    if (bus.bitslip === 1'b1 && bus.dly_ld === 1'b1) overlap_seen++;
    if (bus.dly_ld === 1'b1) ld_taps.push_back(int'(bus.dly_tap));
    refresh();
    #1;
  endtask

  task automatic clear_stats();
    rot           = 0;
    slips_seen    = 0;
    overlap_seen  = 0;
    min_gap       = 1000000;
    last_slip_cyc = -1;
    ld_taps.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_locked(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bus.locked === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    mode = M_CONST;
    const_val = 8'h00;
    refresh();
    repeat (3) step();
    vectors++;
    if ({bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b want 0", {bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy});
    end
    rst = 1'b0;
    repeat (2) step();
    vectors++;
    if ({bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL idle_outputs: got %b want 0", {bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy});
    end
  endtask

  task automatic test_aligned();
    int n;
    mode = M_CONST;
    const_val = PAT;
    refresh();
    clear_stats();
    pulse_start();
    vectors++;
    if (bus.dly_ld !== 1'b1 || bus.dly_tap !== 5'd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL aligned_first_load: got ld=%b tap=%0d busy=%b want ld=1 tap=0 busy=1", bus.dly_ld, bus.dly_tap, bus.busy);
    end
    wait_locked(500, n);
    vectors++;
    if (n != 81) begin
      miscompares++;
      $display("[TB] FAIL aligned_lock_latency: got %0d want 81", n);
    end
    vectors++;
    if (bus.slip_cnt !== 3'd0 || bus.dly_tap !== 5'd0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL aligned_lock_state: got slip=%0d tap=%0d busy=%b want 0 0 0", bus.slip_cnt, bus.dly_tap, bus.busy);
    end
    vectors++;
    if (slips_seen != 0 || ld_taps.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL aligned_pulses: got slips=%0d loads=%0d want 0 1", slips_seen, ld_taps.size());
    end
    // start while locked restarts the search
    pulse_start();
    vectors++;
    if (bus.locked !== 1'b0 || bus.dly_ld !== 1'b1 || bus.dly_tap !== 5'd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL locked_restart: got lk=%b ld=%b tap=%0d busy=%b want 0 1 0 1", bus.locked, bus.dly_ld, bus.dly_tap, bus.busy);
    end
    wait_locked(500, n);
    vectors++;
    if (n != 81) begin
      miscompares++;
      $display("[TB] FAIL relock_latency: got %0d want 81", n);
    end
  endtask

  task automatic test_rotated(input int k);
    int n;
    mode = M_ROT;
    rot_base = rotl(PAT, 8 - k);
    clear_stats();
    refresh();
    pulse_start();
    wait_locked(2000, n);
    vectors++;
    if (n != 81 + 18 * k) begin
      miscompares++;
      $display("[TB] FAIL rot%0d_lock_latency: got %0d want %0d", k, n, 81 + 18 * k);
    end
    vectors++;
    if (int'(bus.slip_cnt) != k || bus.dly_tap !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL rot%0d_lock_state: got slip=%0d tap=%0d want slip=%0d tap=0", k, bus.slip_cnt, bus.dly_tap, k);
    end
    vectors++;
    if (slips_seen != k || overlap_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL rot%0d_pulses: got slips=%0d overlap=%0d want %0d 0", k, slips_seen, overlap_seen, k);
    end
    if (k >= 2) begin
      vectors++;
      if (min_gap < 17) begin
        miscompares++;
        $display("[TB] FAIL rot%0d_slip_gap: got %0d want >=17", k, min_gap);
      end
    end
  endtask

  task automatic test_tap_search(input int t);
    int n;
    mode = M_TAP;
    good_tap = t;
    clear_stats();
    refresh();
    pulse_start();
    wait_locked(3000, n);
    vectors++;
    if (n != 144 * t + 81) begin
      miscompares++;
      $display("[TB] FAIL tap%0d_lock_latency: got %0d want %0d", t, n, 144 * t + 81);
    end
    vectors++;
    if (int'(bus.dly_tap) != t || bus.slip_cnt !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL tap%0d_lock_state: got tap=%0d slip=%0d want tap=%0d slip=0", t, bus.dly_tap, bus.slip_cnt, t);
    end
    vectors++;
    if (slips_seen != 7 * t || overlap_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL tap%0d_slips: got slips=%0d overlap=%0d want %0d 0", t, slips_seen, overlap_seen, 7 * t);
    end
    vectors++;
    if (ld_taps.size() != t + 1) begin
      miscompares++;
      $display("[TB] FAIL tap%0d_load_count: got %0d want %0d", t, ld_taps.size(), t + 1);
    end
    for (int i = 0; i < ld_taps.size(); i++) begin
      vectors++;
      if (ld_taps[i] != i) begin
        miscompares++;
        $display("[TB] FAIL tap%0d_load_seq[%0d]: got %0d want %0d", t, i, ld_taps[i], i);
      end
    end
  endtask

  task automatic test_exhaustion();
    int n;
    mode = M_CONST;
    const_val = 8'h00;
    clear_stats();
    refresh();
    pulse_start();
    n = -1;
    for (int i = 1; i <= 6000; i++) begin
      step();
      if (bus.fail === 1'b1) begin
        n = i;
        break;
      end
    end
    vectors++;
    if (n != 4608) begin
      miscompares++;
      $display("[TB] FAIL exhaust_latency: got %0d want 4608", n);
    end
    vectors++;
    if (bus.dly_tap !== 5'd31 || bus.locked !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL exhaust_state: got tap=%0d lk=%b busy=%b want 31 0 0", bus.dly_tap, bus.locked, bus.busy);
    end
    vectors++;
    if (slips_seen != 224 || ld_taps.size() != 32) begin
      miscompares++;
      $display("[TB] FAIL exhaust_pulses: got slips=%0d loads=%0d want 224 32", slips_seen, ld_taps.size());
    end
    repeat ($urandom_range(3, 10)) step();
    vectors++;
    if (bus.fail !== 1'b1 || bus.dly_tap !== 5'd31) begin
      miscompares++;
      $display("[TB] FAIL fail_hold: got fail=%b tap=%0d want 1 31", bus.fail, bus.dly_tap);
    end
    const_val = PAT;
    refresh();
    pulse_start();
    vectors++;
    if (bus.fail !== 1'b0 || bus.dly_ld !== 1'b1 || bus.dly_tap !== 5'd0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fail_restart: got fail=%b ld=%b tap=%0d busy=%b want 0 1 0 1", bus.fail, bus.dly_ld, bus.dly_tap, bus.busy);
    end
    wait_locked(500, n);
    vectors++;
    if (n != 81) begin
      miscompares++;
      $display("[TB] FAIL fail_relock_latency: got %0d want 81", n);
    end
  endtask

  task automatic test_loss_of_lock();
    int n;
    int len;
    mode = M_CONST;
    for (int b = 0; b < 4; b++) begin
      len = (b == 0) ? 3 : $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        const_val = garbage();
        refresh();
        step();
        vectors++;
        if (bus.locked !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL loss_burst%0d_hold: got %b want 1", b, bus.locked);
        end
      end
      const_val = PAT;
      refresh();
      step();
    end
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      const_val = garbage();
      refresh();
      step();
      vectors++;
      if (i < 3) begin
        if (bus.locked !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL loss_mismatch%0d_hold: got %b want 1", i, bus.locked);
        end
      end else begin
        if (bus.locked !== 1'b0 || bus.dly_ld !== 1'b1 || bus.dly_tap !== 5'd0 || bus.busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL loss_drop: got lk=%b ld=%b tap=%0d busy=%b want 0 1 0 1", bus.locked, bus.dly_ld, bus.dly_tap, bus.busy);
        end
      end
    end
    const_val = PAT;
    refresh();
    wait_locked(500, n);
    vectors++;
    if (n != 81) begin
      miscompares++;
      $display("[TB] FAIL loss_relock_latency: got %0d want 81", n);
    end
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    mode = M_ROT;
    rot_base = 8'h1E;
    clear_stats();
    refresh();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.bitslip === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL midreset_slip_seen: got 0 want 1");
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b want 0", {bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy});
    end
    rst = 1'b0;
    repeat (3) step();
    vectors++;
    if ({bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy} !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_idle: got %b want 0", {bus.bitslip, bus.dly_ld, bus.dly_tap, bus.slip_cnt, bus.locked, bus.fail, bus.busy});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    mode = M_CONST;
    const_val = PAT;
    refresh();
    clear_stats();
    pulse_start();
    gap = $urandom_range(2, 30);
    repeat (gap) step();
    pulse_start();
    wait_locked(500, n);
    vectors++;
    if (n != 81 - gap - 1) begin
      miscompares++;
      $display("[TB] FAIL busy_start_latency: got %0d want %0d", n, 81 - gap - 1);
    end
    vectors++;
    if (ld_taps.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL busy_start_loads: got %0d want 1", ld_taps.size());
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.fr_in = 8'h00;
    rst = 1'b1;
    test_reset();
    test_aligned();
    test_rotated(3);
    test_rotated($urandom_range(0, 7));
    test_rotated($urandom_range(0, 7));
    test_tap_search(5);
    test_tap_search($urandom_range(1, 3));
    test_exhaustion();
    test_loss_of_lock();
    test_reset_mid_search();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
